// File: rtl/ml_vec_dot_engine.sv
// rtl/ml_vec_dot_engine.sv - streaming signed fixed-point dot-product engine
// Optional ML_DOT_SAT_EN: clamp out_data on overflow instead of wrapping.
module ml_vec_dot_engine #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 2,
  parameter int VEC_LEN = 8,
  parameter int OUT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_ovf
);

  localparam int ACC_W = 2*DATA_W + $clog2(VEC_LEN) + 1;
  localparam int BEATS = VEC_LEN / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int PROD_W = 2*DATA_W;

  generate
    if ((VEC_LEN % LANES) != 0) begin : g_len_check
      $error("ml_vec_dot_engine: VEC_LEN must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, beat_sum;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     fire;
  logic                     ovf_raw;
  logic [OUT_W-1:0]         wrap_data;

  logic signed [PROD_W-1:0] a_ext [LANES];
  logic signed [PROD_W-1:0] b_ext [LANES];
  logic signed [PROD_W-1:0] prod  [LANES];

  // Operands are widened first so every product is exact at 2*DATA_W bits.
  for (genvar g = 0; g < LANES; g++) begin : g_mul
    assign a_ext[g] = (PROD_W)'($signed(in_a[g*DATA_W +: DATA_W]));
    assign b_ext[g] = (PROD_W)'($signed(in_b[g*DATA_W +: DATA_W]));
    assign prod[g]  = a_ext[g] * b_ext[g];
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + (ACC_W)'(prod[i]);
    end
  end

  assign in_ready  = rst_n && (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign fire      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (abort) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (fire) begin
          acc_d   = beat_sum;
          cnt_d   = (CNT_W)'(1);
          state_d = (BEATS == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (abort) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (fire) begin
          acc_d = acc_q + beat_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == (CNT_W)'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        // abort is deliberately not looked at here: a finished result is never dropped
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (ACC_W > OUT_W) begin : g_ovf
      // Fits iff every bit from the OUT_W sign position upward is identical.
      assign ovf_raw = !((&acc_q[ACC_W-1:OUT_W-1]) || !(|acc_q[ACC_W-1:OUT_W-1]));
    end else begin : g_no_ovf
      assign ovf_raw = 1'b0;
    end
  endgenerate

  assign wrap_data = (OUT_W)'(acc_q);
  assign out_ovf   = out_valid && ovf_raw;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef ML_DOT_SAT_EN
      if (ovf_raw)
        out_data = acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      else
        out_data = wrap_data;
`else
      out_data = wrap_data;
`endif
    end
  end

endmodule

// File: tb/tb_ml_vec_dot_engine.sv
// tb/tb_ml_vec_dot_engine.sv - directed plus randomized bench for ml_vec_dot_engine
module tb_ml_vec_dot_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  ml_vec_dot_engine #(.DATA_W(8), .LANES(2), .VEC_LEN(8), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer dot product, then the 16-bit output rules.
  function automatic logic [16:0] model(input int a[8], input int b[8]);
    longint s = 0;
    logic [15:0] d;
    logic o;
    for (int i = 0; i < 8; i++) s += longint'(a[i]) * longint'(b[i]);
    o = (s > 32767) || (s < -32768);
    d = s[15:0];
`ifdef ML_DOT_SAT_EN
    if (o) d = (s > 0) ? 16'h7fff : 16'h8000;
`endif
    return {o, d};
  endfunction

  task automatic drive(input int a[8], input int b[8], input int k);
    for (int l = 0; l < 2; l++) begin
      in_a[l*8 +: 8] = 8'(a[k*2+l]);
      in_b[l*8 +: 8] = 8'(b[k*2+l]);
    end
  endtask

  task automatic send(input int a[8], input int b[8], input int nbeats,
                      input int bubble_pct, input string tag);
    int k = 0;
    int guard = 0;
    logic took;
    while (k < nbeats && guard < 500) begin
      @(negedge clk);
      if (k > 0) chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
      if (int'($urandom_range(0, 99)) < bubble_pct) begin
        in_valid = 1'b0;
        in_a = 'x;
        in_b = 'x;
      end else begin
        in_valid = 1'b1;
        drive(a, b, k);
      end
      took = in_valid && in_ready;
      @(posedge clk);
      if (took) k++;
      guard++;
    end
    if (k < nbeats) chk({tag, " beat_timeout"}, 32'(k), 32'(nbeats));
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 'x;
    in_b = 'x;
  endtask

  // Called at the first falling edge after the final beat.
  task automatic collect(input int a[8], input int b[8], input int hold, input string tag);
    logic [16:0] m;
    m = model(a, b);
    chk({tag, " latency_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, 32'(out_data), 32'(m[15:0]));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(m[16]));
    chk({tag, " done_ready"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      abort     = (h == 1);
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_data"}, 32'(out_data), 32'(m[15:0]));
      chk({tag, " hold_ready"}, 32'(in_ready), 32'd0);
    end
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " post_ready"}, 32'(in_ready), 32'd1);
  endtask

  int a[8];
  int b[8];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin a[i] = 1; b[i] = i + 1; end
    send(a, b, 4, 0, "ones");
    collect(a, b, 0, "ones");

    for (int i = 0; i < 8; i++) begin a[i] = -128; b[i] = -128; end
    send(a, b, 4, 0, "neg128");
    collect(a, b, 0, "neg128");

    for (int i = 0; i < 8; i++) begin a[i] = 1; b[i] = i + 1; end
    send(a, b, 4, 50, "bubbles");
    collect(a, b, 0, "bubbles");

    send(a, b, 4, 0, "stall");
    collect(a, b, 5, "stall");

    for (int i = 0; i < 8; i++) begin a[i] = $urandom_range(0, 255) - 128; b[i] = 7; end
    send(a, b, 2, 0, "abort_pre");
    in_valid = 1'b1;
    abort    = 1'b1;
    drive(a, b, 2);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin a[i] = 2; b[i] = 3; end
    send(a, b, 4, 0, "after_abort");
    collect(a, b, 0, "after_abort");

    for (int i = 0; i < 8; i++) begin a[i] = 100; b[i] = 100; end
    send(a, b, 3, 0, "reset_pre");
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'd0);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", 32'(out_data), 32'd0);
    chk("midreset out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin a[i] = -1; b[i] = 5; end
    send(a, b, 4, 0, "after_reset");
    collect(a, b, 0, "after_reset");

    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < 8; i++) begin
        if (v % 4 == 3) begin
          a[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
          b[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
        end else begin
          a[i] = int'($urandom_range(0, 255)) - 128;
          b[i] = int'($urandom_range(0, 255)) - 128;
        end
      end
      send(a, b, 4, 30, "rand");
      collect(a, b, int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
